// File: rtl/cam_refill_ctrl_pkg.sv
// Shared types and constants for the CAM refill controller.
package cam_refill_ctrl_pkg;

  // Each key is built from packs of five bits.
  localparam int unsigned PACK_W    = 5;
  localparam int unsigned DEF_PACKS = 4;
  localparam int unsigned KEY_W     = DEF_PACKS * PACK_W;

  // Refill sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UPD  = 2'd1,
    WAIT = 2'd2
  } refill_state_e;

  // Key width for an arbitrary pack count.
  function automatic int unsigned key_bits(input int unsigned packs);
    return packs * PACK_W;
  endfunction

endpackage

// File: rtl/prio_enc.sv
// Lowest-set-bit priority encoder with an any-bit-set flag.
module prio_enc #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]                          vec,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0]  idx,
  output logic                                  any
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  // Scan from the top down so the lowest set bit wins.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = IW'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cam_refill_ctrl.sv
// Refill controller for a small CAM: victim selection, update strobe
// sequencing, per-entry valid tracking and masked hit reporting.
module cam_refill_ctrl
  import cam_refill_ctrl_pkg::*;
#(
  parameter int unsigned ENTRIES         = 8,
  parameter int unsigned PACKS_OF_5_BITS = 4
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    refill_valid_i,
  output logic                                    refill_ready_o,
  input  logic [PACKS_OF_5_BITS-1:0][PACK_W-1:0]  refill_key_i,
  input  logic                                    flush_i,
  output logic [ENTRIES-1:0]                      entry_update_o,
  output logic [PACKS_OF_5_BITS-1:0][PACK_W-1:0]  entry_set_key_o,
  input  logic [ENTRIES-1:0]                      entry_raw_hit_i,
  output logic [ENTRIES-1:0]                      hit_vec_o,
  output logic                                    hit_o,
  output logic [$clog2(ENTRIES)-1:0]              hit_idx_o,
  output logic                                    multi_hit_o,
  output logic                                    busy_o
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);

  typedef logic [PACKS_OF_5_BITS-1:0][PACK_W-1:0] key_t;

  refill_state_e state_q, state_d;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [IDX_W-1:0]   victim_q, victim_d;
  key_t               key_q, key_d;
  logic               flush_seen_q, flush_seen_d;

  logic               accept;
  logic [IDX_W-1:0]   free_idx;
  logic               free_any;
  logic [IDX_W-1:0]   victim_sel;
  logic [ENTRIES-1:0] invalid_vec;

  assign invalid_vec = ~valid_q;

  // Lowest-index invalid entry is the preferred victim.
  prio_enc #(.N(ENTRIES)) u_free_enc (
    .vec (invalid_vec),
    .idx (free_idx),
    .any (free_any)
  );

  // Lowest-index masked hit.
  prio_enc #(.N(ENTRIES)) u_hit_enc (
    .vec (hit_vec_o),
    .idx (hit_idx_o),
    .any (hit_o)
  );

  assign accept     = (state_q == IDLE) && refill_valid_i;
  assign victim_sel = free_any ? free_idx : rr_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: one accept launches a fixed three-cycle sequence.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (refill_valid_i) state_d = UPD;
      UPD:     state_d = WAIT;
      WAIT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: capture, valid bookkeeping, pointer and flush tracking.
  always_comb begin
    valid_d      = valid_q;
    rr_d         = rr_q;
    key_d        = key_q;
    victim_d     = victim_q;
    flush_seen_d = flush_seen_q;

    if (accept) begin
      key_d               = refill_key_i;
      victim_d            = victim_sel;
      valid_d[victim_sel] = 1'b0;
      flush_seen_d        = 1'b0;
      if (!free_any) begin
        rr_d = rr_q + IDX_W'(1);
      end
    end

    // A flush mid-sequence must keep the new entry from going valid.
    if ((state_q != IDLE) && flush_i) begin
      flush_seen_d = 1'b1;
    end

    // The CAM entry holds the new key two cycles after its update strobe.
    if ((state_q == WAIT) && !flush_seen_q && !flush_i) begin
      valid_d[victim_q] = 1'b1;
    end

    if (flush_i) begin
      valid_d = '0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= '0;
      rr_q         <= '0;
      key_q        <= '0;
      victim_q     <= '0;
      flush_seen_q <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      rr_q         <= rr_d;
      key_q        <= key_d;
      victim_q     <= victim_d;
      flush_seen_q <= flush_seen_d;
    end
  end

  // Output decode from registered state.
  assign refill_ready_o  = (state_q == IDLE);
  assign busy_o          = (state_q != IDLE);
  assign entry_update_o  = (state_q == UPD) ? (ENTRIES'(1) << victim_q) : '0;
  assign entry_set_key_o = key_q;

  // Hits only count for entries whose contents are known good.
  assign hit_vec_o   = entry_raw_hit_i & valid_q;
  assign multi_hit_o = |(hit_vec_o & (hit_vec_o - ENTRIES'(1)));

endmodule

// File: tb/tb_cam_refill_ctrl.sv
// Self-checking bench for cam_refill_ctrl: cycle-level reference model with
// per-cycle comparison plus directed literal checks.
module tb_cam_refill_ctrl;

  localparam int E = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             refill_valid = 1'b0;
  logic             flush = 1'b0;
  logic [3:0][4:0]  key = '0;
  logic [E-1:0]     raw = '0;

  logic             ready;
  logic [E-1:0]     update;
  logic [3:0][4:0]  set_key;
  logic [E-1:0]     hit_vec;
  logic             hit;
  logic [2:0]       hit_idx;
  logic             multi;
  logic             busy;

  int errors = 0;
  int checks = 0;

  cam_refill_ctrl #(.ENTRIES(E), .PACKS_OF_5_BITS(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .refill_valid_i  (refill_valid),
    .refill_ready_o  (ready),
    .refill_key_i    (key),
    .flush_i         (flush),
    .entry_update_o  (update),
    .entry_set_key_o (set_key),
    .entry_raw_hit_i (raw),
    .hit_vec_o       (hit_vec),
    .hit_o           (hit),
    .hit_idx_o       (hit_idx),
    .multi_hit_o     (multi),
    .busy_o          (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: time-based view of the refill rules.
  int          cyc = 0;
  int          last_acc = -100;
  logic [E-1:0] m_valid = '0;
  int          m_ptr = 0;
  int          m_victim = 0;
  logic [19:0] m_key = '0;
  bit          seq_fl = 1'b0;
  bit          model_ok = 1'b0;

  always @(posedge clk) begin
    bit acc;
    int old;
    int v;
    if (rst) begin
      m_valid  = '0;
      m_ptr    = 0;
      m_key    = '0;
      m_victim = 0;
      last_acc = -100;
      seq_fl   = 1'b0;
      cyc      = 0;
      model_ok = 1'b1;
    end else begin
      old = last_acc;
      acc = refill_valid && (cyc >= old + 3);
      if ((cyc == old + 1 || cyc == old + 2) && flush) seq_fl = 1'b1;
      if (cyc == old + 2 && !seq_fl) m_valid[m_victim] = 1'b1;
      if (acc) begin
        v = -1;
        for (int i = 0; i < E; i++) if (v < 0 && !m_valid[i]) v = i;
        if (v < 0) begin
          v = m_ptr;
          m_ptr = (m_ptr + 1) % E;
        end
        m_victim   = v;
        m_valid[v] = 1'b0;
        m_key      = key;
        last_acc   = cyc;
        seq_fl     = 1'b0;
      end
      if (flush) m_valid = '0;
      cyc++;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic [E-1:0] ehv;
    int eidx;
    if (model_ok) begin
      ehv  = raw & m_valid;
      eidx = 0;
      for (int i = E - 1; i >= 0; i--) if (ehv[i]) eidx = i;
      chk("m_ready",   32'(ready),   32'(cyc >= last_acc + 3));
      chk("m_busy",    32'(busy),    32'(cyc < last_acc + 3));
      chk("m_update",  32'(update),  (cyc == last_acc + 1) ? 32'(1 << m_victim) : 32'd0);
      chk("m_set_key", 32'(set_key), 32'(m_key));
      chk("m_hit_vec", 32'(hit_vec), 32'(ehv));
      chk("m_hit",     32'(hit),     32'(ehv != '0));
      chk("m_hit_idx", 32'(hit_idx), 32'(eidx));
      chk("m_multi",   32'(multi),   32'($countones(ehv) > 1));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Present a refill for one cycle; returns in the cycle after acceptance.
  task automatic refill(input logic [19:0] k);
    refill_valid = 1'b1;
    key          = k;
    step();
    refill_valid = 1'b0;
  endtask

  task automatic refill_full(input logic [19:0] k, input logic [7:0] exp_upd, input string name);
    refill(k);
    @(negedge clk);
    chk(name, 32'(update), 32'(exp_upd));
    step();
    step();
  endtask

  initial begin
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    raw = 8'hFF;
    @(negedge clk);
    chk("rst_ready",   32'(ready),   32'd1);
    chk("rst_busy",    32'(busy),    32'd0);
    chk("rst_update",  32'(update),  32'd0);
    chk("rst_set_key", 32'(set_key), 32'd0);
    chk("rst_hit_vec", 32'(hit_vec), 32'd0);
    chk("rst_hit",     32'(hit),     32'd0);
    chk("rst_hit_idx", 32'(hit_idx), 32'd0);
    chk("rst_multi",   32'(multi),   32'd0);
    step();

    // First refill: strobe at A+1, hit masked until A+3.
    raw = 8'h01;
    refill(20'h12345);
    @(negedge clk);
    chk("a1_update",  32'(update),  32'h01);
    chk("a1_set_key", 32'(set_key), 32'h12345);
    chk("a1_hit",     32'(hit),     32'd0);
    step();
    @(negedge clk);
    chk("a2_hit",     32'(hit),     32'd0);
    chk("a2_update",  32'(update),  32'd0);
    step();
    @(negedge clk);
    chk("a3_hit",     32'(hit),     32'd1);
    chk("a3_hit_idx", 32'(hit_idx), 32'd0);

    // Fill remaining entries, then round-robin replacement.
    raw = 8'h00;
    for (int i = 1; i < E; i++) refill_full(20'(i + 16), 8'(1 << i), "fill_update");
    refill_full(20'h00009, 8'h01, "rr9_update");
    refill_full(20'h0000A, 8'h02, "rr10_update");
    for (int i = 2; i < 7; i++) refill_full(20'(i + 32), 8'(1 << i), "rr_update");
    refill_full(20'h00077, 8'h80, "rr_ptr7_update");
    refill_full(20'h00088, 8'h01, "rr_wrap_update");

    // Masked multi-hit.
    raw = 8'h14;
    @(negedge clk);
    chk("mh_hit_vec", 32'(hit_vec), 32'h14);
    chk("mh_hit_idx", 32'(hit_idx), 32'd2);
    chk("mh_multi",   32'(multi),   32'd1);
    step();

    // Reset in the middle of a sequence.
    raw = 8'h00;
    refill(20'hABCDE);
    rst = 1'b1;
    step();
    rst = 1'b0;
    raw = 8'hFF;
    @(negedge clk);
    chk("rstmid_update",  32'(update),  32'd0);
    chk("rstmid_hit_vec", 32'(hit_vec), 32'd0);
    step();

    // Flush during WAIT of a refill into entry 3.
    raw = 8'h00;
    refill_full(20'h00100, 8'h01, "pre_update");
    refill_full(20'h00101, 8'h02, "pre_update");
    refill_full(20'h00102, 8'h04, "pre_update");
    refill(20'h00103);
    @(negedge clk);
    chk("fw_update_a1", 32'(update), 32'h08);
    step();
    flush = 1'b1;
    @(negedge clk);
    chk("fw_update_a2", 32'(update), 32'd0);
    step();
    flush = 1'b0;
    raw = 8'h08;
    @(negedge clk);
    chk("fw_hit",     32'(hit),     32'd0);
    chk("fw_hit_vec", 32'(hit_vec), 32'd0);
    step();

    // Flush during UPD: strobe completes, entry stays invalid.
    raw = 8'h00;
    refill(20'h00200);
    flush = 1'b1;
    @(negedge clk);
    chk("fu_update_a1", 32'(update), 32'h01);
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("fu_update_a2", 32'(update), 32'd0);
    step();
    raw = 8'h01;
    @(negedge clk);
    chk("fu_hit", 32'(hit), 32'd0);
    step();

    // Flush and refill in the same idle cycle: only the victim survives.
    raw = 8'h00;
    refill_full(20'h00300, 8'h01, "ff_pre_update");
    refill_full(20'h00301, 8'h02, "ff_pre_update");
    flush = 1'b1;
    refill(20'h00302);
    flush = 1'b0;
    @(negedge clk);
    chk("ff_update", 32'(update), 32'h04);
    step();
    step();
    raw = 8'hFF;
    @(negedge clk);
    chk("ff_hit_vec", 32'(hit_vec), 32'h04);
    chk("ff_hit_idx", 32'(hit_idx), 32'd2);
    step();

    // Back-to-back requests: ready pattern 1,0,0.
    raw = 8'h00;
    refill_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      key = 20'(i + 20'h400);
      @(negedge clk);
      chk("b2b_ready", 32'(ready), 32'((i % 3) == 0));
      step();
    end
    refill_valid = 1'b0;
    step();
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
